// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button front end.
// Provides default timing parameters and the counter-width function.
package btn_pkg;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_REPEAT_RATE  = 8;

  // Bits needed to hold 0..max; never returns 0.
  function automatic int cnt_w(int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

  // Auto-repeat interval being timed.
  typedef enum logic {
    RPT_FIRST,
    RPT_NEXT
  } rpt_phase_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce, repeat timer, pulses.
// Ports: clk, reset (async low), raw in; pulse, held, press_evt out.
module btn_channel
  import btn_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic held,
  output logic press_evt
);

  localparam int DBW = cnt_w(DEBOUNCE_CYC);
  localparam int RPMAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW = cnt_w(RPMAX);
  localparam bit RPT_EN = (REPEAT_DELAY > 0);

  logic [SYNC_STAGES-1:0] sync;
  logic [DBW-1:0]         cnt;
  logic                   sync_out;
  logic                   toggle;
  logic                   rise;

  logic [RPW-1:0]         rpt;
  logic [RPW-1:0]         rpt_nxt;
  logic [RPW-1:0]         target;
  rpt_phase_e             phase;
  logic                   rpt_run;
  logic                   rpt_hit;

  assign sync_out = sync[SYNC_STAGES-1];
  assign toggle   = (sync_out != held) &&
                    (cnt == DBW'(DEBOUNCE_CYC - 1));
  assign rise     = toggle && !held;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw ^ ACTIVE_LOW};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      held <= 1'b0;
    end else if (sync_out == held) begin
      cnt <= '0;
    end else if (toggle) begin
      cnt  <= '0;
      held <= ~held;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Repeat timer only runs while held and not on the edge where
  // held changes, so a release can never fire a late repeat.
  assign rpt_run = held && !toggle;
  assign rpt_nxt = rpt + 1'b1;
  assign target  = (phase == RPT_FIRST) ? RPW'(REPEAT_DELAY)
                                        : RPW'(REPEAT_RATE);
  assign rpt_hit = RPT_EN && rpt_run && (rpt_nxt == target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt   <= '0;
      phase <= RPT_FIRST;
    end else if (!rpt_run) begin
      rpt   <= '0;
      phase <= RPT_FIRST;
    end else if (rpt_nxt == target) begin
      rpt   <= '0;
      phase <= RPT_NEXT;
    end else begin
      rpt <= rpt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse     <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      pulse     <= rise | rpt_hit;
      press_evt <= rise;
    end
  end

endmodule

// File: rtl/button_pulse_array.sv
// N-channel push-button front end built from btn_channel instances.
// Ports: clk, reset (async low), btn_raw; pulse, held, press_evt.
module button_pulse_array
  import btn_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] press_evt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw       (btn_raw[i]),
      .pulse     (pulse[i]),
      .held      (held[i]),
      .press_evt (press_evt[i])
    );
  end

endmodule

// File: tb/tb_button_pulse_array.sv
// Scoreboard bench for button_pulse_array.
// Three builds: defaults, auto-repeat, active-high.
module tb_button_pulse_array;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_a, raw_r, raw_h;
  logic [3:0] pulse_a, pulse_r, pulse_h;
  logic [3:0] held_a, held_r, held_h;
  logic [3:0] press_a, press_r, press_h;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] e;
  } exp_t;

  exp_t q_a[$];
  exp_t q_r[$];
  exp_t q_h[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_pulse_array u_a (
    .clk(clk), .reset(reset), .btn_raw(raw_a),
    .pulse(pulse_a), .held(held_a), .press_evt(press_a)
  );

  button_pulse_array #(
    .REPEAT_DELAY(20), .REPEAT_RATE(8)
  ) u_r (
    .clk(clk), .reset(reset), .btn_raw(raw_r),
    .pulse(pulse_r), .held(held_r), .press_evt(press_r)
  );

  button_pulse_array #(
    .ACTIVE_LOW(1'b0)
  ) u_h (
    .clk(clk), .reset(reset), .btn_raw(raw_h),
    .pulse(pulse_h), .held(held_h), .press_evt(press_h)
  );

  task automatic push(int w, int c, logic [3:0] p, logic [3:0] e);
    exp_t x;
    x.cyc = c;
    x.p   = p;
    x.e   = e;
    case (w)
      0: q_a.push_back(x);
      1: q_r.push_back(x);
      default: q_h.push_back(x);
    endcase
  endtask

  task automatic mon(string nm, int w, logic [3:0] p, logic [3:0] e);
    exp_t x;
    int   n;
    n = (w == 0) ? q_a.size() : (w == 1) ? q_r.size() : q_h.size();
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL %s unexpected pulse=%b press_evt=%b cyc=%0d",
               nm, p, e, cyc);
      return;
    end
    case (w)
      0: x = q_a.pop_front();
      1: x = q_r.pop_front();
      default: x = q_h.pop_front();
    endcase
    if (x.cyc != cyc || x.p != p || x.e != e) begin
      errors++;
      $display("FAIL %s got cyc=%0d pulse=%b evt=%b need cyc=%0d pulse=%b evt=%b",
               nm, cyc, p, e, x.cyc, x.p, x.e);
    end
  endtask

  always @(negedge clk) if (|{pulse_a, press_a}) mon("dut_a", 0, pulse_a, press_a);
  always @(negedge clk) if (|{pulse_r, press_r}) mon("dut_r", 1, pulse_r, press_r);
  always @(negedge clk) if (|{pulse_h, press_h}) mon("dut_h", 2, pulse_h, press_h);

  task automatic chk(string nm, logic [3:0] got, logic [3:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got=%b need=%b cyc=%0d", nm, got, need, cyc);
    end
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic leftover(string nm, int n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s missing %0d expected pulses got=0 need=%0d", nm, n, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running need=done");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int p;
    int r;
    reset = 1'b0;
    raw_a = 4'hF;
    raw_r = 4'hF;
    raw_h = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_held_a", held_a, 4'h0);
    chk("rst_pulse_a", pulse_a | press_a, 4'h0);
    chk("rst_held_r", held_r | pulse_r, 4'h0);
    chk("rst_held_h", held_h | pulse_h, 4'h0);
    reset = 1'b1;

    // basic press/release on ch0
    c = cyc + 2;
    wait_to(c);
    raw_a[0] = 1'b0;
    push(0, c + 6, 4'b0001, 4'b0001);
    wait_to(c + 5);
    chk("t1_held_early", held_a, 4'h0);
    wait_to(c + 6);
    chk("t1_held", held_a, 4'b0001);
    wait_to(c + 10);
    raw_a[0] = 1'b1;
    wait_to(c + 15);
    chk("t1_held_keep", held_a, 4'b0001);
    wait_to(c + 16);
    chk("t1_release", held_a, 4'h0);

    // 3-cycle glitch on ch1
    c = cyc + 4;
    wait_to(c);
    raw_a[1] = 1'b0;
    wait_to(c + 3);
    raw_a[1] = 1'b1;
    wait_to(c + 12);
    chk("t2_glitch", held_a, 4'h0);

    // bounce then settle on ch2
    c = cyc + 4;
    wait_to(c);
    raw_a[2] = 1'b0;
    wait_to(c + 1);
    raw_a[2] = 1'b1;
    wait_to(c + 2);
    raw_a[2] = 1'b0;
    wait_to(c + 3);
    raw_a[2] = 1'b1;
    wait_to(c + 4);
    raw_a[2] = 1'b0;
    push(0, c + 10, 4'b0100, 4'b0100);
    wait_to(c + 9);
    chk("t3_early", held_a, 4'h0);
    wait_to(c + 10);
    chk("t3_held", held_a, 4'b0100);
    wait_to(c + 14);
    raw_a[2] = 1'b1;
    wait_to(c + 24);

    // auto-repeat
    c = cyc + 2;
    wait_to(c);
    raw_r[0] = 1'b0;
    p = c + 6;
    push(1, p, 4'b0001, 4'b0001);
    for (int k = 20; k <= 52; k += 8) push(1, p + k, 4'b0001, 4'b0000);
    wait_to(c + 60);
    raw_r[0] = 1'b1;
    wait_to(c + 65);
    chk("t4_held", held_r, 4'b0001);
    wait_to(c + 66);
    chk("t4_release", held_r, 4'h0);
    wait_to(c + 100);

    // all channels together, both polarities
    c = cyc + 2;
    wait_to(c);
    raw_a = 4'h0;
    raw_h = 4'hF;
    push(0, c + 6, 4'hF, 4'hF);
    push(2, c + 6, 4'hF, 4'hF);
    wait_to(c + 6);
    chk("t5_held_a", held_a, 4'hF);
    chk("t5_held_h", held_h, 4'hF);
    wait_to(c + 10);
    raw_a = 4'hF;
    raw_h = 4'h0;
    wait_to(c + 30);

    // reset mid-repeat and mid-debounce
    c = cyc + 2;
    wait_to(c);
    raw_r[2] = 1'b0;
    p = c + 6;
    push(1, p, 4'b0100, 4'b0100);
    push(1, p + 20, 4'b0100, 4'b0000);
    wait_to(c + 28);
    raw_a[0] = 1'b0;
    wait_to(c + 30);
    chk("t6_pre_held_r", held_r, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_r", held_r | pulse_r | press_r, 4'h0);
    chk("t6_rst_a", held_a | pulse_a | press_a, 4'h0);
    repeat (2) @(negedge clk);
    r = cyc;
    reset = 1'b1;
    push(0, r + 6, 4'b0001, 4'b0001);
    push(1, r + 6, 4'b0100, 4'b0100);
    wait_to(r + 5);
    chk("t6_early", held_a | held_r, 4'h0);
    wait_to(r + 6);
    chk("t6_held_a", held_a, 4'b0001);
    chk("t6_held_r", held_r, 4'b0100);
    wait_to(r + 10);
    raw_a[0] = 1'b1;
    raw_r[2] = 1'b1;
    wait_to(r + 40);
    chk("t6_final", held_a | held_r, 4'h0);

    leftover("q_a", q_a.size());
    leftover("q_r", q_r.size());
    leftover("q_h", q_h.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
